// File: rtl/apb_protocol_monitor.sv
// ---------------------------------------------------------------------------
// apb_protocol_monitor
//
// Passive APB3 bus monitor and protocol checker. It watches a requester /
// completer pair and never drives the bus. It tracks the bus phase
// (IDLE / SETUP / ACCESS), flags protocol violations, counts completed
// transfers and violating cycles, and captures the last completed transfer.
//
// Optional feature macro: APB_MON_XCHK_EN
//   When defined, error bit [5] flags X/Z values on the bus. This check is
//   for simulation only.
//   When undefined, bit [5] is tied to 0 and no X logic is built.
//
// Parameters:
//   ADDR_W   paddr width
//   DATA_W   pwdata / prdata width
//   TIMEOUT  max consecutive wait cycles before a timeout error (>= 1)
//   CNT_W    width of the saturating transfer / violation counters
//
// Ports:
//   clk_i         clock; every input is sampled on the rising edge
//   reset         synchronous, active-high reset
//   psel, penable, pwrite, paddr, pwdata, prdata, pready   observed APB bus
//   clr_i         clears err_sticky_o, xfer_cnt_o and viol_cnt_o
//   err_pulse_o   per-check error flags, one-cycle pulse
//                 [0] SEQ  [1] SETUP  [2] STABLE  [3] DROP  [4] TIMEOUT  [5] XCHK
//   err_sticky_o  OR-accumulation of err_pulse_o until clr_i / reset
//   done_o        one-cycle pulse when a transfer completes
//   last_addr_o   paddr of the last completed transfer
//   last_data_o   pwdata (write) or prdata (read) of the last completed transfer
//   last_write_o  pwrite of the last completed transfer
//   xfer_cnt_o    completed transfers, saturating
//   viol_cnt_o    cycles with at least one error, saturating
// ---------------------------------------------------------------------------
module apb_protocol_monitor #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              clr_i,
    output logic [5:0]        err_pulse_o,
    output logic [5:0]        err_sticky_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] last_addr_o,
    output logic [DATA_W-1:0] last_data_o,
    output logic              last_write_o,
    output logic [CNT_W-1:0]  xfer_cnt_o,
    output logic [CNT_W-1:0]  viol_cnt_o
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    // The state is the bus phase seen at the previous clock edge.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t            state;
    logic [WCNT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_write;
    logic [DATA_W-1:0] lat_wdata;

    logic              sel_en;
    logic              changed;
    logic              complete;
    logic [WCNT_W-1:0] wait_next;
    logic              wait_timeout;
    logic              xchk;
    logic [5:0]        err_now;
    logic [CNT_W-1:0]  xfer_base;
    logic [CNT_W-1:0]  viol_base;
    logic [5:0]        sticky_base;

    assign sel_en       = psel & penable;
    assign complete     = (state != ST_IDLE) & sel_en & pready;
    assign wait_next    = wait_cnt + WCNT_W'(1);
    assign wait_timeout = (wait_next == WCNT_W'(TIMEOUT));

    // Write data only matters for writes; a read may drive anything on pwdata.
    assign changed = (paddr != lat_addr) | (pwrite != lat_write) |
                     (lat_write & (pwdata != lat_wdata));

`ifdef APB_MON_XCHK_EN
    // Control and address must always be known. Write data must be known
    // while a write is in SETUP or ACCESS. Read data only on a completing read.
    assign xchk = $isunknown({psel, penable, pwrite, paddr}) |
                  ((((state == ST_IDLE) & psel & ~penable & pwrite) |
                    ((state != ST_IDLE) & lat_write)) & $isunknown(pwdata)) |
                  (complete & ~pwrite & $isunknown(prdata));
`else
    assign xchk = 1'b0;
`endif

    // Error vector for the current cycle, derived from the phase we are leaving.
    always_comb begin
        err_now = '0;
        case (state)
            ST_IDLE: begin
                err_now[0] = penable;
            end
            ST_SETUP: begin
                if (sel_en) begin
                    err_now[2] = changed;
                    // Entering ACCESS with pready low is already the first wait cycle.
                    err_now[4] = ~pready & (TIMEOUT == 1);
                end else begin
                    err_now[1] = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (sel_en) begin
                    err_now[2] = changed;
                    err_now[4] = ~pready & wait_timeout;
                end else begin
                    err_now[3] = 1'b1;
                end
            end
            default: begin
                err_now = '0;
            end
        endcase
        err_now[5] = xchk;
    end

    // A clear takes effect first; the event of the same cycle is then applied.
    assign xfer_base   = clr_i ? '0 : xfer_cnt_o;
    assign viol_base   = clr_i ? '0 : viol_cnt_o;
    assign sticky_base = clr_i ? '0 : err_sticky_o;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            lat_addr     <= '0;
            lat_write    <= 1'b0;
            lat_wdata    <= '0;
            err_pulse_o  <= '0;
            err_sticky_o <= '0;
            done_o       <= 1'b0;
            last_addr_o  <= '0;
            last_data_o  <= '0;
            last_write_o <= 1'b0;
            xfer_cnt_o   <= '0;
            viol_cnt_o   <= '0;
        end else begin
            err_pulse_o  <= err_now;
            err_sticky_o <= sticky_base | err_now;
            done_o       <= complete;

            if (complete) begin
                last_addr_o  <= paddr;
                last_write_o <= pwrite;
                last_data_o  <= pwrite ? pwdata : prdata;
            end

            if (complete && !(&xfer_base)) begin
                xfer_cnt_o <= xfer_base + CNT_W'(1);
            end else begin
                xfer_cnt_o <= xfer_base;
            end

            if ((|err_now) && !(&viol_base)) begin
                viol_cnt_o <= viol_base + CNT_W'(1);
            end else begin
                viol_cnt_o <= viol_base;
            end

            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (psel && !penable) begin
                        state     <= ST_SETUP;
                        lat_addr  <= paddr;
                        lat_write <= pwrite;
                        lat_wdata <= pwdata;
                    end
                end
                ST_SETUP: begin
                    if (sel_en && !pready) begin
                        state    <= ST_ACCESS;
                        wait_cnt <= WCNT_W'(1);
                    end else begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (sel_en && !pready) begin
                        wait_cnt <= wait_next;
                    end else begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                end
            endcase

            // Any violation abandons the transfer being tracked.
            if (|err_now) begin
                state    <= ST_IDLE;
                wait_cnt <= '0;
            end
        end
    end

endmodule
